// File: rtl/spectro_frame_receiver.sv
// Receiver for the spectrogram extractor's serial readout: rebuilds the 32-bit timestamp and
// the ch1/ch2 sample pairs, and buffers pairs in a small first-word-fall-through FIFO.
module spectro_frame_receiver #(
    parameter int TIME_BITS   = 32,
    parameter int SAMPLE_BITS = 3,
    parameter int FIFO_DEPTH  = 4,
    parameter int CNT_W       = 9
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sending_data,
    input  logic                     SL_time,
    input  logic                     SL_ch,
    input  logic [1:0]               serial_in,
    output logic [TIME_BITS-1:0]     event_time,
    output logic                     time_valid,
    output logic [2*SAMPLE_BITS-1:0] sample_data,
    output logic                     sample_valid,
    input  logic                     sample_ready,
    output logic                     frame_done,
    output logic [CNT_W-1:0]         frame_samples,
    output logic                     frame_error,
    output logic                     overflow
);

    localparam int TCNT_W = $clog2(TIME_BITS);
    localparam int BCNT_W = $clog2(SAMPLE_BITS);
    localparam int DATA_W = 2 * SAMPLE_BITS;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int OCC_W  = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_TIME,
        S_SAMPLES
    } state_t;

    state_t                 state_q;
    logic                   sd_q;
    logic [TIME_BITS-1:0]   tshift_q;
    logic [TCNT_W-1:0]      tcnt_q;
    logic [SAMPLE_BITS-1:0] c1_q;
    logic [SAMPLE_BITS-1:0] c2_q;
    logic [BCNT_W-1:0]      bcnt_q;
    logic [CNT_W-1:0]       frame_cnt_q;
    logic [TIME_BITS-1:0]   event_time_q;
    logic                   time_valid_q;
    logic                   frame_done_q;
    logic                   frame_error_q;
    logic [CNT_W-1:0]       frame_samples_q;
    logic                   push_q;
    logic [DATA_W-1:0]      push_data_q;

    logic rise;
    logic fall;

    assign rise = sending_data & ~sd_q;
    assign fall = ~sending_data & sd_q;

    // sd_q resets high so a frame already running at reset release is skipped entirely.
    // NOTE: all sequential state uses non-blocking assignments so every register samples
    // the pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= S_IDLE;
            sd_q            <= 1'b1;
            tshift_q        <= '0;
            tcnt_q          <= '0;
            c1_q            <= '0;
            c2_q            <= '0;
            bcnt_q          <= '0;
            frame_cnt_q     <= '0;
            event_time_q    <= '0;
            time_valid_q    <= 1'b0;
            frame_done_q    <= 1'b0;
            frame_error_q   <= 1'b0;
            frame_samples_q <= '0;
            push_q          <= 1'b0;
            push_data_q     <= '0;
        end else begin
            sd_q          <= sending_data;
            time_valid_q  <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_error_q <= 1'b0;
            push_q        <= 1'b0;

            if (fall && state_q != S_IDLE) begin
                // Bits presented in the fall cycle are not sampled; a partial pair is discarded.
                frame_done_q    <= 1'b1;
                frame_samples_q <= frame_cnt_q;
                frame_error_q   <= (state_q == S_TIME) || (bcnt_q != '0);
                state_q         <= S_IDLE;
                tcnt_q          <= '0;
                bcnt_q          <= '0;
                frame_cnt_q     <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (rise) begin
                            state_q <= S_TIME;
                            tcnt_q  <= '0;
                            if (SL_time) begin
                                tshift_q <= {tshift_q[TIME_BITS-2:0], serial_in[0]};
                                tcnt_q   <= TCNT_W'(1);
                            end
                        end
                    end
                    S_TIME: begin
                        if (sending_data && SL_time) begin
                            tshift_q <= {tshift_q[TIME_BITS-2:0], serial_in[0]};
                            if (tcnt_q == TCNT_W'(TIME_BITS - 1)) begin
                                event_time_q <= {tshift_q[TIME_BITS-2:0], serial_in[0]};
                                time_valid_q <= 1'b1;
                                tcnt_q       <= '0;
                                state_q      <= S_SAMPLES;
                            end else begin
                                tcnt_q <= tcnt_q + TCNT_W'(1);
                            end
                        end
                    end
                    S_SAMPLES: begin
                        if (sending_data && SL_ch) begin
                            c1_q <= {c1_q[SAMPLE_BITS-2:0], serial_in[0]};
                            c2_q <= {c2_q[SAMPLE_BITS-2:0], serial_in[1]};
                            if (bcnt_q == BCNT_W'(SAMPLE_BITS - 1)) begin
                                push_q      <= 1'b1;
                                push_data_q <= {c1_q[SAMPLE_BITS-2:0], serial_in[0],
                                                c2_q[SAMPLE_BITS-2:0], serial_in[1]};
                                bcnt_q      <= '0;
                                if (frame_cnt_q != '1) begin
                                    frame_cnt_q <= frame_cnt_q + CNT_W'(1);
                                end
                            end else begin
                                bcnt_q <= bcnt_q + BCNT_W'(1);
                            end
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    // Sample-pair FIFO, written one cycle after the FSM completes a pair.
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [OCC_W-1:0]  occ_q;
    logic              overflow_q;
    logic              full;
    logic              pop;
    logic              wr_en;

    assign full  = (occ_q == OCC_W'(FIFO_DEPTH));
    assign pop   = sample_valid & sample_ready;
    assign wr_en = push_q & (~full | pop);

    // NOTE: the storage array is reset on purpose: it is only a few flops, and clearing it
    // keeps sample_data at zero after reset instead of exposing stale contents.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= push_data_q;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            occ_q <= occ_q + OCC_W'(wr_en) - OCC_W'(pop);
            if (push_q && full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign event_time    = event_time_q;
    assign time_valid    = time_valid_q;
    assign sample_data   = mem_q[rd_ptr_q];
    assign sample_valid  = (occ_q != '0);
    assign frame_done    = frame_done_q;
    assign frame_samples = frame_samples_q;
    assign frame_error   = frame_error_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_spectro_frame_receiver.sv
// Self-checking bench for spectro_frame_receiver: drives serial frames and compares the
// FIFO output against a scoreboard of expected sample pairs.
module tb_spectro_frame_receiver;

    logic        clk;
    logic        reset;
    logic        sending_data;
    logic        SL_time;
    logic        SL_ch;
    logic [1:0]  serial_in;
    logic [31:0] event_time;
    logic        time_valid;
    logic [5:0]  sample_data;
    logic        sample_valid;
    logic        sample_ready;
    logic        frame_done;
    logic [8:0]  frame_samples;
    logic        frame_error;
    logic        overflow;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [5:0]  exp_q[$];
    logic [5:0]  exp_head;

    spectro_frame_receiver dut (
        .clk           (clk),
        .reset         (reset),
        .sending_data  (sending_data),
        .SL_time       (SL_time),
        .SL_ch         (SL_ch),
        .serial_in     (serial_in),
        .event_time    (event_time),
        .time_valid    (time_valid),
        .sample_data   (sample_data),
        .sample_valid  (sample_valid),
        .sample_ready  (sample_ready),
        .frame_done    (frame_done),
        .frame_samples (frame_samples),
        .frame_error   (frame_error),
        .overflow      (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Handshake seen at the negedge completes at the next posedge.
    always @(negedge clk) begin
        if (reset && sample_valid && sample_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 64'(exp_q.size()), 64'd1);
            end else begin
                exp_head = exp_q.pop_front();
                check("sample_data", 64'(sample_data), 64'(exp_head));
            end
        end
    end

    task automatic cyc(input logic sd, input logic slt, input logic slc, input logic [1:0] s);
        sending_data = sd;
        SL_time      = slt;
        SL_ch        = slc;
        serial_in    = s;
        @(posedge clk);
        #1;
    endtask

    task automatic send_time(input logic [31:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            cyc(1'b1, 1'b1, 1'b0, {1'b0, w[31-i]});
        end
    endtask

    task automatic send_bits(input logic [2:0] c1, input logic [2:0] c2, input int nb);
        for (int b = 0; b < nb; b++) begin
            cyc(1'b1, 1'b0, 1'b1, {c2[2-b], c1[2-b]});
        end
    endtask

    task automatic send_pair(input logic [2:0] c1, input logic [2:0] c2, input bit keep);
        send_bits(c1, c2, 3);
        if (keep) exp_q.push_back({c1, c2});
    endtask

    task automatic end_frame(input logic exp_err, input logic [8:0] exp_n);
        cyc(1'b0, 1'b0, 1'b0, 2'b00);
        check("frame_done", 64'(frame_done), 64'd1);
        check("frame_error", 64'(frame_error), 64'(exp_err));
        check("frame_samples", 64'(frame_samples), 64'(exp_n));
        cyc(1'b0, 1'b0, 1'b0, 2'b00);
        check("frame_done_pulse", 64'(frame_done), 64'd0);
        check("frame_error_pulse", 64'(frame_error), 64'd0);
    endtask

    task automatic drain();
        sample_ready = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 2'b00);
        end
        cyc(1'b0, 1'b0, 1'b0, 2'b00);
        check("drain_left", 64'(exp_q.size()), 64'd0);
        check("drain_empty", 64'(sample_valid), 64'd0);
    endtask

    initial begin
        reset        = 1'b0;
        sample_ready = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 2'b00);
        cyc(1'b0, 1'b0, 1'b0, 2'b00);
        check("rst_event_time", 64'(event_time), 64'd0);
        check("rst_time_valid", 64'(time_valid), 64'd0);
        check("rst_sample_valid", 64'(sample_valid), 64'd0);
        check("rst_sample_data", 64'(sample_data), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_frame_samples", 64'(frame_samples), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        reset = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 2'b00);

        // Full frame: timestamp then two pairs, consumer always ready.
        sample_ready = 1'b1;
        send_time(32'hA5C3_0F17, 32);
        check("t2_event_time", 64'(event_time), 64'hA5C3_0F17);
        check("t2_time_valid", 64'(time_valid), 64'd1);
        send_pair(3'b101, 3'b010, 1'b1);
        check("t2_time_valid_pulse", 64'(time_valid), 64'd0);
        check("t2_latency_n", 64'(sample_valid), 64'd0);
        cyc(1'b1, 1'b0, 1'b0, 2'b00);
        check("t2_latency_n1", 64'(sample_valid), 64'd1);
        check("t2_head", 64'(sample_data), 64'b101010);
        send_pair(3'b111, 3'b000, 1'b1);
        end_frame(1'b0, 9'd2);
        drain();

        // Header truncated after 20 bits.
        send_time(32'h0BAD_F00D, 20);
        end_frame(1'b1, 9'd0);
        check("t3_event_time_kept", 64'(event_time), 64'hA5C3_0F17);
        check("t3_time_valid", 64'(time_valid), 64'd0);

        // Fall in the middle of the third pair.
        send_time(32'h1234_5678, 32);
        check("t4_event_time", 64'(event_time), 64'h1234_5678);
        send_pair(3'b001, 3'b110, 1'b1);
        send_pair(3'b010, 3'b011, 1'b1);
        send_bits(3'b111, 3'b111, 2);
        end_frame(1'b1, 9'd2);
        drain();

        // Full FIFO with push and pop in the same cycle.
        sample_ready = 1'b0;
        send_time(32'hFFFF_0000, 32);
        send_pair(3'b000, 3'b001, 1'b1);
        send_pair(3'b010, 3'b011, 1'b1);
        send_pair(3'b100, 3'b101, 1'b1);
        send_pair(3'b110, 3'b111, 1'b1);
        send_pair(3'b011, 3'b100, 1'b1);
        sample_ready = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 2'b00);
        sample_ready = 1'b0;
        check("t6_no_overflow", 64'(overflow), 64'd0);
        cyc(1'b1, 1'b0, 1'b0, 2'b00);
        check("t6_valid", 64'(sample_valid), 64'd1);
        end_frame(1'b0, 9'd5);
        check("t6_no_overflow_end", 64'(overflow), 64'd0);
        drain();

        // Five pairs into four entries with the consumer stalled.
        sample_ready = 1'b0;
        send_time(32'h0000_0001, 32);
        send_pair(3'b001, 3'b010, 1'b1);
        send_pair(3'b011, 3'b100, 1'b1);
        send_pair(3'b101, 3'b110, 1'b1);
        send_pair(3'b111, 3'b001, 1'b1);
        send_pair(3'b100, 3'b100, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 2'b00);
        check("t5_overflow", 64'(overflow), 64'd1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 2'b00);
        check("t5_overflow_sticky", 64'(overflow), 64'd1);
        end_frame(1'b0, 9'd5);
        drain();
        check("t5_overflow_after_drain", 64'(overflow), 64'd1);

        // Reset mid-frame, released while sending_data is still high.
        sample_ready = 1'b0;
        send_time(32'hDEAD_BEEF, 10);
        reset = 1'b0;
        send_time(32'hDEAD_BEEF, 3);
        check("t1_in_reset_overflow", 64'(overflow), 64'd0);
        reset = 1'b1;
        send_time(32'h5555_AAAA, 32);
        check("t1_no_time_valid", 64'(time_valid), 64'd0);
        check("t1_event_time", 64'(event_time), 64'd0);
        check("t1_sample_valid", 64'(sample_valid), 64'd0);
        check("t1_frame_samples", 64'(frame_samples), 64'd0);
        cyc(1'b0, 1'b0, 1'b0, 2'b00);
        check("t1_no_frame_done", 64'(frame_done), 64'd0);
        send_time(32'hC0FF_EE11, 32);
        check("t1_recapture", 64'(event_time), 64'hC0FF_EE11);
        check("t1_recapture_valid", 64'(time_valid), 64'd1);
        end_frame(1'b0, 9'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
